mem_req_demux: RTL and testbench
================================

// Module: mem_req_demux
// PURPOSE
//  1-to-2 request demultiplexer with response return path: the counterpart of the 32-bit 2:1 data mux.
//  Routes one core memory request stream (valid/ready) to target 0 (cache) or target 1 (uncached/MMIO),
//  selected per request by SEL. Each target's response is returned on a single merged response port.
//  Responses come back in request order, because a target switch waits until all outstanding requests have drained.
// PARAMETERS
//  DW        32  data width (WDATA/RDATA)
//  AW        32  address width
//  MAX_OUTST 4   max outstanding (accepted, unresponded) requests; counter width = $clog2(MAX_OUTST+1)
// PORTS
//  CLK         in   1   clock, all state on rising edge
//  RST         in   1   asynchronous, active-high reset
//  IN_VALID    in   1   core request valid
//  IN_READY    out  1   request accepted when IN_VALID & IN_READY
//  IN_ADDR     in   AW  request address
//  IN_WDATA    in   DW  write data
//  IN_WE       in   1   1=write, 0=read
//  SEL         in   1   target select, sampled with the request (0 -> OUT0, 1 -> OUT1)
//  OUTn_VALID  out  1   target n request valid (n = 0,1), registered
//  OUTn_READY  in   1   target n accepts request
//  OUTn_ADDR   out  AW  registered address; OUTn_WDATA out DW; OUTn_WE out 1
//  RSPn_VALID  in   1   target n response valid (1 cycle per request, no backpressure)
//  RSPn_RDATA  in   DW  target n response data (don't-care for writes)
//  RSP_VALID   out  1   merged response valid, registered
//  RSP_RDATA   out  DW  merged response data, registered
//  ERR         out  1   sticky protocol error (DEMUX_ERR_EN only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset: IN_READY=0 while RST is high and 1 after release if the accept rules allow it; OUTn_VALID=0, OUTn_ADDR/WDATA=0, OUTn_WE=0,
//    RSP_VALID=0, RSP_RDATA=0, ERR=0. Buffer empty, outst=0, cur_tgt=0.
//  - One-entry request buffer {addr,wdata,we,tgt}. OUT[tgt]_VALID = buf_full; other OUTn_VALID=0. Other target's payload holds its last value.
//  - Request latency: accepted at edge k -> OUTn_VALID high in cycle k+1. Buffer frees on OUT[tgt]_VALID&OUT[tgt]_READY.
//  - Accept rule: IN_READY = (!buf_full | drain) & (outst_next < MAX_OUTST) & (SEL==cur_tgt | outst==0 & !buf_full),
//    where drain = buf_full & OUT[buf_tgt]_READY. Same-cycle drain+accept is allowed (full throughput, one request per cycle).
//  - A SEL switch stalls IN_READY until the buffer is empty and outst==0. cur_tgt updates on acceptance.
//  - outst: +1 on acceptance, -1 on accepted response (RSP[cur_tgt]_VALID); both in the same cycle -> unchanged.
//    Never exceeds MAX_OUTST; at MAX_OUTST, IN_READY=0.
//  - Response path: RSP_VALID<=RSP[cur_tgt]_VALID & (outst!=0); RSP_RDATA<=RSP[cur_tgt]_RDATA. Response latency is 1 cycle.
//  - Stray response (RSPn_VALID for the non-current target, or when outst==0): dropped, counter unchanged.
//  - Simultaneous RSP0_VALID & RSP1_VALID: only cur_tgt is used; the other is a stray response.
//  - Reset mid-operation: all state clears immediately (async). In-flight target responses after reset are strays.
// CONFIGURATION
//  DEMUX_ERR_EN defined: ERR is set on the cycle after any stray response, or after IN_VALID with SEL/IN_ADDR/IN_WDATA/IN_WE
//    changing while IN_VALID & !IN_READY (request not held stable). ERR stays set until RST.
//  DEMUX_ERR_EN undefined: ERR is driven constant 0; strays are silently dropped; no stability checking logic.
// TESTING
//  1 Reset: RST=1 mid-burst -> next cycle all OUTn_VALID=0, RSP_VALID=0, ERR=0; after release IN_READY=1.
//  2 Back-to-back SEL=0 reads A=0x100,0x104,0x108, OUT0_READY=1 -> OUT0_VALID for 3 consecutive cycles starting 1 cycle
//    after the first accept; OUT1_VALID stays 0.
//  3 Target switch: SEL=0 read outstanding, then SEL=1 write 0x8000_0000 -> IN_READY=0 until RSP0_VALID; request accepted the
//    cycle after RSP0_VALID; OUT1_VALID one cycle later; responses ordered on RSP_VALID.
//  4 Backpressure: OUT0_READY=0 for 5 cycles -> OUT0_VALID, OUT0_ADDR held stable; IN_READY=0 while buffer is full; drain resumes at 1/cycle.
//  5 Limit: 4 SEL=0 requests with no responses -> 5th stalls (IN_READY=0); RSP0_VALID with RDATA=0xDEADBEEF -> RSP_RDATA=0xDEADBEEF
//    next cycle, 5th accepted.
//  6 DEMUX_ERR_EN: RSP1_VALID while cur_tgt=0 -> RSP_VALID stays 0, ERR=1 next cycle and held; without the macro, ERR=0.

Source files
------------

// File: rtl/mem_req_demux.sv
// mem_req_demux: routes one valid/ready request stream to cache (0) or MMIO (1), merges responses in order.
// Optional DEMUX_ERR_EN enables a sticky ERR flag for stray responses and unstable stalled requests.
module mem_req_demux #(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [AW-1:0] IN_ADDR,
   input  logic [DW-1:0] IN_WDATA,
   input  logic          IN_WE,
   input  logic          SEL,
   output logic          OUT0_VALID,
   input  logic          OUT0_READY,
   output logic [AW-1:0] OUT0_ADDR,
   output logic [DW-1:0] OUT0_WDATA,
   output logic          OUT0_WE,
   output logic          OUT1_VALID,
   input  logic          OUT1_READY,
   output logic [AW-1:0] OUT1_ADDR,
   output logic [DW-1:0] OUT1_WDATA,
   output logic          OUT1_WE,
   input  logic          RSP0_VALID,
   input  logic [DW-1:0] RSP0_RDATA,
   input  logic          RSP1_VALID,
   input  logic [DW-1:0] RSP1_RDATA,
   output logic          RSP_VALID,
   output logic [DW-1:0] RSP_RDATA,
   output logic          ERR
);

   localparam int unsigned   CW        = $clog2(MAX_OUTST + 1);
   localparam logic [CW-1:0] OUTST_LIM = CW'(MAX_OUTST);

   logic [1:0]          vld_q, vld_d;
   logic [1:0][AW-1:0]  addr_q, addr_d;
   logic [1:0][DW-1:0]  wdata_q, wdata_d;
   logic [1:0]          we_q, we_d;
   logic                cur_q, cur_d;
   logic [CW-1:0]       outst_q, outst_d, outst_rsp;
   logic                rsp_vld_q, rsp_vld_d;
   logic [DW-1:0]       rsp_data_q, rsp_data_d;

   logic buf_full, drain, rsp_cur, rsp_take, in_ready, accept;

   always_comb begin
      buf_full  = |vld_q;
      drain     = (vld_q[0] & OUT0_READY) | (vld_q[1] & OUT1_READY);
      rsp_cur   = cur_q ? RSP1_VALID : RSP0_VALID;
      rsp_take  = rsp_cur & (outst_q != '0);
      outst_rsp = outst_q - CW'(rsp_take);
      // a response retiring this cycle frees a slot for a same-cycle accept
      in_ready  = !RST & (!buf_full | drain) & (outst_rsp < OUTST_LIM)
                & ((SEL == cur_q) | ((outst_q == '0) & !buf_full));
      accept    = IN_VALID & in_ready;

      vld_d   = vld_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      cur_d   = cur_q;
      if (drain) vld_d = '0;
      if (accept) begin
         vld_d          = SEL ? 2'b10 : 2'b01;
         addr_d[SEL]    = IN_ADDR;
         wdata_d[SEL]   = IN_WDATA;
         we_d[SEL]      = IN_WE;
         cur_d          = SEL;
      end
      outst_d    = outst_rsp + CW'(accept);
      rsp_vld_d  = rsp_take;
      rsp_data_d = cur_q ? RSP1_RDATA : RSP0_RDATA;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= '0;
         cur_q      <= 1'b0;
         outst_q    <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         vld_q      <= vld_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         cur_q      <= cur_d;
         outst_q    <= outst_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign IN_READY   = in_ready;
   assign OUT0_VALID = vld_q[0];
   assign OUT0_ADDR  = addr_q[0];
   assign OUT0_WDATA = wdata_q[0];
   assign OUT0_WE    = we_q[0];
   assign OUT1_VALID = vld_q[1];
   assign OUT1_ADDR  = addr_q[1];
   assign OUT1_WDATA = wdata_q[1];
   assign OUT1_WE    = we_q[1];
   assign RSP_VALID  = rsp_vld_q;
   assign RSP_RDATA  = rsp_data_q;

`ifdef DEMUX_ERR_EN
   logic                err_q, err_d, stall_q, stray;
   logic [AW+DW+1:0]    req_now, req_q;

   always_comb begin
      req_now = {SEL, IN_WE, IN_ADDR, IN_WDATA};
      stray   = (RSP0_VALID & (cur_q | (outst_q == '0)))
              | (RSP1_VALID & (!cur_q | (outst_q == '0)));
      err_d   = err_q | stray | (stall_q & IN_VALID & (req_now != req_q));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err_q   <= 1'b0;
         stall_q <= 1'b0;
         req_q   <= '0;
      end else begin
         err_q   <= err_d;
         stall_q <= IN_VALID & !in_ready;
         req_q   <= req_now;
      end
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_demux.sv
// Directed self-checking bench for mem_req_demux; ERR expectations follow DEMUX_ERR_EN.
module tb_mem_req_demux;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IN_VALID = 1'b0, IN_WE = 1'b0, SEL = 1'b0;
   logic [31:0] IN_ADDR = '0, IN_WDATA = '0;
   logic        IN_READY;
   logic        OUT0_VALID, OUT0_WE, OUT1_VALID, OUT1_WE;
   logic        OUT0_READY = 1'b1, OUT1_READY = 1'b1;
   logic [31:0] OUT0_ADDR, OUT0_WDATA, OUT1_ADDR, OUT1_WDATA;
   logic        RSP0_VALID = 1'b0, RSP1_VALID = 1'b0;
   logic [31:0] RSP0_RDATA = '0, RSP1_RDATA = '0;
   logic        RSP_VALID, ERR;
   logic [31:0] RSP_RDATA;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

`ifdef DEMUX_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   mem_req_demux #(.DW(32), .AW(32), .MAX_OUTST(4)) dut (
      .CLK(CLK), .RST(RST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_ADDR(IN_ADDR),
      .IN_WDATA(IN_WDATA), .IN_WE(IN_WE), .SEL(SEL),
      .OUT0_VALID(OUT0_VALID), .OUT0_READY(OUT0_READY), .OUT0_ADDR(OUT0_ADDR),
      .OUT0_WDATA(OUT0_WDATA), .OUT0_WE(OUT0_WE),
      .OUT1_VALID(OUT1_VALID), .OUT1_READY(OUT1_READY), .OUT1_ADDR(OUT1_ADDR),
      .OUT1_WDATA(OUT1_WDATA), .OUT1_WE(OUT1_WE),
      .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA),
      .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic in_req(input logic sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      IN_VALID = 1'b1;
      SEL      = sel;
      IN_WE    = we;
      IN_ADDR  = addr;
      IN_WDATA = wdata;
   endtask

   task automatic rsp_burst(input logic tgt, input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         if (tgt) begin RSP1_VALID = 1'b1; RSP1_RDATA = base + 32'(i); end
         else     begin RSP0_VALID = 1'b1; RSP0_RDATA = base + 32'(i); end
         tick; settle;
         chk("rsp_valid", RSP_VALID, 1);
         chk("rsp_rdata", RSP_RDATA, base + 32'(i));
      end
      RSP0_VALID = 1'b0;
      RSP1_VALID = 1'b0;
      tick; settle;
      chk("rsp_idle", RSP_VALID, 0);
   endtask

   initial begin
      // reset values
      repeat (3) tick;
      settle;
      chk("rst_in_ready", IN_READY, 0);
      chk("rst_out0_valid", OUT0_VALID, 0);
      chk("rst_out1_valid", OUT1_VALID, 0);
      chk("rst_out0_addr", OUT0_ADDR, 0);
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_rsp_rdata", RSP_RDATA, 0);
      chk("rst_err", ERR, 0);
      tick; RST = 1'b0; settle;
      chk("rel_in_ready", IN_READY, 1);

      // back-to-back SEL=0 reads
      in_req(1'b0, 1'b0, 32'h100, 32'h0);
      settle;
      chk("b2b_ready0", IN_READY, 1);
      tick; IN_ADDR = 32'h104; settle;
      chk("b2b_v0", OUT0_VALID, 1);
      chk("b2b_a0", OUT0_ADDR, 32'h100);
      chk("b2b_out1_off", OUT1_VALID, 0);
      chk("b2b_ready1", IN_READY, 1);
      tick; IN_ADDR = 32'h108; settle;
      chk("b2b_v1", OUT0_VALID, 1);
      chk("b2b_a1", OUT0_ADDR, 32'h104);
      tick; IN_VALID = 1'b0; settle;
      chk("b2b_v2", OUT0_VALID, 1);
      chk("b2b_a2", OUT0_ADDR, 32'h108);
      chk("b2b_we", OUT0_WE, 0);
      tick; settle;
      chk("b2b_done", OUT0_VALID, 0);
      chk("b2b_out1_off2", OUT1_VALID, 0);
      rsp_burst(1'b0, 3, 32'h1100);

      // target switch: SEL=1 write waits for the SEL=0 read to respond
      in_req(1'b0, 1'b0, 32'h200, 32'h0);
      tick;
      in_req(1'b1, 1'b1, 32'h8000_0000, 32'h0000_CAFE);
      settle;
      chk("sw_stall0", IN_READY, 0);
      chk("sw_out0_v", OUT0_VALID, 1);
      tick; settle;
      chk("sw_stall1", IN_READY, 0);
      chk("sw_out0_drained", OUT0_VALID, 0);
      tick; RSP0_VALID = 1'b1; RSP0_RDATA = 32'hAAAA_5555; settle;
      chk("sw_stall_rsp", IN_READY, 0);
      tick; RSP0_VALID = 1'b0; settle;
      chk("sw_rsp_valid", RSP_VALID, 1);
      chk("sw_rsp_rdata", RSP_RDATA, 32'hAAAA_5555);
      chk("sw_ready", IN_READY, 1);
      tick; IN_VALID = 1'b0; settle;
      chk("sw_out1_v", OUT1_VALID, 1);
      chk("sw_out1_a", OUT1_ADDR, 32'h8000_0000);
      chk("sw_out1_we", OUT1_WE, 1);
      chk("sw_out1_wd", OUT1_WDATA, 32'h0000_CAFE);
      chk("sw_out0_off", OUT0_VALID, 0);
      chk("sw_out0_hold", OUT0_ADDR, 32'h200);
      chk("sw_rsp_idle", RSP_VALID, 0);
      tick; settle;
      chk("sw_out1_drained", OUT1_VALID, 0);
      rsp_burst(1'b1, 1, 32'h0);

      // backpressure on target 0
      OUT0_READY = 1'b0;
      in_req(1'b0, 1'b0, 32'h300, 32'h0);
      settle;
      chk("bp_ready0", IN_READY, 1);
      tick; IN_ADDR = 32'h304;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick;
         settle;
         chk("bp_hold_v", OUT0_VALID, 1);
         chk("bp_hold_a", OUT0_ADDR, 32'h300);
         chk("bp_stall", IN_READY, 0);
      end
      tick; OUT0_READY = 1'b1; settle;
      chk("bp_resume_ready", IN_READY, 1);
      chk("bp_resume_a", OUT0_ADDR, 32'h300);
      tick; IN_ADDR = 32'h308; settle;
      chk("bp_a1", OUT0_ADDR, 32'h304);
      chk("bp_v1", OUT0_VALID, 1);
      tick; IN_VALID = 1'b0; settle;
      chk("bp_a2", OUT0_ADDR, 32'h308);
      tick; settle;
      chk("bp_done", OUT0_VALID, 0);
      rsp_burst(1'b0, 3, 32'h3000);

      // outstanding limit
      in_req(1'b0, 1'b0, 32'h400, 32'h0);
      for (int i = 1; i < 5; i++) begin
         tick; IN_ADDR = 32'h400 + 32'(4 * i);
      end
      settle;
      chk("lim_stall0", IN_READY, 0);
      tick; settle;
      chk("lim_stall1", IN_READY, 0);
      RSP0_VALID = 1'b1; RSP0_RDATA = 32'hDEAD_BEEF; settle;
      chk("lim_ready_on_rsp", IN_READY, 1);
      tick; RSP0_VALID = 1'b0; IN_VALID = 1'b0; settle;
      chk("lim_rsp_valid", RSP_VALID, 1);
      chk("lim_rsp_rdata", RSP_RDATA, 32'hDEAD_BEEF);
      chk("lim_5th_v", OUT0_VALID, 1);
      chk("lim_5th_a", OUT0_ADDR, 32'h410);
      tick; settle;
      chk("lim_still_full", IN_READY, 0);
      rsp_burst(1'b0, 4, 32'h4000);
      chk("lim_drained_ready", IN_READY, 1);
      chk("lim_err_clean", ERR, 0);

      // stray responses
      in_req(1'b0, 1'b0, 32'h600, 32'h0);
      tick; IN_VALID = 1'b0;
      tick;
      RSP0_VALID = 1'b1; RSP0_RDATA = 32'h77;
      RSP1_VALID = 1'b1; RSP1_RDATA = 32'h99;
      tick; RSP0_VALID = 1'b0; RSP1_VALID = 1'b0; settle;
      chk("both_rsp_valid", RSP_VALID, 1);
      chk("both_rsp_rdata", RSP_RDATA, 32'h77);
      chk("both_err", ERR, EXP_ERR);
      RSP1_VALID = 1'b1; RSP1_RDATA = 32'h55;
      tick; RSP1_VALID = 1'b0; settle;
      chk("stray_dropped", RSP_VALID, 0);
      chk("stray_err", ERR, EXP_ERR);
      repeat (2) tick;
      settle;
      chk("stray_err_held", ERR, EXP_ERR);
      chk("stray_ready", IN_READY, 1);

      // reset mid-burst
      OUT0_READY = 1'b0;
      in_req(1'b0, 1'b0, 32'h500, 32'h0);
      tick; IN_ADDR = 32'h504; settle;
      chk("mid_v", OUT0_VALID, 1);
      RST = 1'b1; IN_VALID = 1'b0; settle;
      chk("mid_rst_v0", OUT0_VALID, 0);
      chk("mid_rst_v1", OUT1_VALID, 0);
      chk("mid_rst_a0", OUT0_ADDR, 0);
      chk("mid_rst_rspv", RSP_VALID, 0);
      chk("mid_rst_err", ERR, 0);
      chk("mid_rst_ready", IN_READY, 0);
      tick; RST = 1'b0; OUT0_READY = 1'b1; settle;
      chk("mid_rel_ready", IN_READY, 1);
      chk("mid_rel_v0", OUT0_VALID, 0);
      RSP0_VALID = 1'b1; RSP0_RDATA = 32'h1234;
      tick; RSP0_VALID = 1'b0; settle;
      chk("mid_late_rsp_dropped", RSP_VALID, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
